// File: rtl/mips_core_pkg.sv
// Shared types for the memory-port arbiter: FSM states, op kind, index-width helper.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_WR_ADDR,
    ARB_WR_DATA,
    ARB_WR_RESP,
    ARB_RD_ADDR,
    ARB_RD_DATA
  } ArbState;

  typedef enum logic {
    ARB_OP_READ,
    ARB_OP_WRITE
  } ArbOp;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_grant_picker
  import mips_core_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               vld,
  output logic [IDX_W-1:0]   idx
);

  int               c;
  logic [IDX_W-1:0] ci;

  // Scan from the farthest slot back to ptr so the nearest hit is written last.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    c   = 0;
    ci  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      ci = IDX_W'(c);
      if (req[ci]) begin
        vld = 1'b1;
        idx = ci;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one AXI-style memory port among NUM_REQ requesters, one whole burst at a time, round-robin.
// Define MEM_ARB_PERF_CNT_EN to add per-requester grant and wait-cycle counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_port_arbiter
  import mips_core_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int LEN_WIDTH = 4,
  localparam int IDX_W     = idx_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_awvalid,
  input  logic [NUM_REQ*`ADDR_WIDTH-1:0]  req_awaddr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_awlen,
  output logic [NUM_REQ-1:0]              req_awready,
  input  logic [NUM_REQ-1:0]              req_wvalid,
  input  logic [NUM_REQ*`DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]              req_wready,
  output logic [NUM_REQ-1:0]              req_bvalid,
  input  logic [NUM_REQ-1:0]              req_arvalid,
  input  logic [NUM_REQ*`ADDR_WIDTH-1:0]  req_araddr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_arlen,
  output logic [NUM_REQ-1:0]              req_arready,
  output logic [NUM_REQ-1:0]              req_rvalid,
  output logic [`DATA_WIDTH-1:0]          req_rdata,
  output logic                            mem_awvalid,
  input  logic                            mem_awready,
  output logic [`ADDR_WIDTH-1:0]          mem_awaddr,
  output logic [LEN_WIDTH-1:0]            mem_awlen,
  output logic [IDX_W-1:0]                mem_awid,
  output logic                            mem_wvalid,
  input  logic                            mem_wready,
  output logic [`DATA_WIDTH-1:0]          mem_wdata,
  output logic                            mem_wlast,
  input  logic                            mem_bvalid,
  output logic                            mem_bready,
  output logic                            mem_arvalid,
  input  logic                            mem_arready,
  output logic [`ADDR_WIDTH-1:0]          mem_araddr,
  output logic [LEN_WIDTH-1:0]            mem_arlen,
  output logic [IDX_W-1:0]                mem_arid,
  input  logic                            mem_rvalid,
  output logic                            mem_rready,
  input  logic [`DATA_WIDTH-1:0]          mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_grants [NUM_REQ],
  output logic [31:0]                     perf_waits  [NUM_REQ]
`endif
);

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;

  logic [AW-1:0]        awaddr_a [NUM_REQ];
  logic [AW-1:0]        araddr_a [NUM_REQ];
  logic [LEN_WIDTH-1:0] awlen_a  [NUM_REQ];
  logic [LEN_WIDTH-1:0] arlen_a  [NUM_REQ];
  logic [DW-1:0]        wdata_a  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign awaddr_a[g] = req_awaddr[g*AW +: AW];
    assign araddr_a[g] = req_araddr[g*AW +: AW];
    assign awlen_a[g]  = req_awlen[g*LEN_WIDTH +: LEN_WIDTH];
    assign arlen_a[g]  = req_arlen[g*LEN_WIDTH +: LEN_WIDTH];
    assign wdata_a[g]  = req_wdata[g*DW +: DW];
  end

  ArbState              state;
  logic [IDX_W-1:0]     grant;
  logic [IDX_W-1:0]     rr_ptr;
  logic [AW-1:0]        addr_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_cnt;

  logic [NUM_REQ-1:0]   cand;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  ArbOp                 pick_op;
  logic [LEN_WIDTH-1:0] pick_len;
  logic                 last_beat;

  assign cand = req_arvalid | req_awvalid;

  rr_grant_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req (cand),
    .ptr (rr_ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // Write wins for a requester with both pending so a dirty flush lands before its refill.
  assign pick_op  = req_awvalid[pick_idx] ? ARB_OP_WRITE : ARB_OP_READ;
  assign pick_len = (pick_op == ARB_OP_WRITE) ? awlen_a[pick_idx] : arlen_a[pick_idx];
  assign last_beat = (beat_cnt == len_q - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (pick_vld) begin
          grant    <= pick_idx;
          rr_ptr   <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          addr_q   <= (pick_op == ARB_OP_WRITE) ? awaddr_a[pick_idx] : araddr_a[pick_idx];
          // A zero length is stored as one beat, and that is what the memory side sees.
          len_q    <= (pick_len == '0) ? LEN_WIDTH'(1) : pick_len;
          beat_cnt <= '0;
          state    <= (pick_op == ARB_OP_WRITE) ? ARB_WR_ADDR : ARB_RD_ADDR;
        end
        ARB_WR_ADDR: if (mem_awready) state <= ARB_WR_DATA;
        ARB_WR_DATA: if (mem_wvalid && mem_wready) begin
          if (last_beat) begin
            beat_cnt <= '0;
            state    <= ARB_WR_RESP;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ARB_WR_RESP: if (mem_bvalid) state <= ARB_IDLE;
        ARB_RD_ADDR: if (mem_arready) state <= ARB_RD_DATA;
        ARB_RD_DATA: if (mem_rvalid) begin
          if (last_beat) begin
            beat_cnt <= '0;
            state    <= ARB_IDLE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    req_awready = '0;
    req_wready  = '0;
    req_bvalid  = '0;
    req_arready = '0;
    req_rvalid  = '0;
    mem_awvalid = 1'b0;
    mem_wvalid  = 1'b0;
    mem_wlast   = 1'b0;
    mem_arvalid = 1'b0;
    case (state)
      ARB_WR_ADDR: begin
        mem_awvalid        = 1'b1;
        req_awready[grant] = mem_awready;
      end
      ARB_WR_DATA: begin
        mem_wvalid        = req_wvalid[grant];
        req_wready[grant] = mem_wready;
        mem_wlast         = last_beat;
      end
      ARB_WR_RESP: req_bvalid[grant] = mem_bvalid;
      ARB_RD_ADDR: begin
        mem_arvalid        = 1'b1;
        req_arready[grant] = mem_arready;
      end
      ARB_RD_DATA: req_rvalid[grant] = mem_rvalid;
      default: ;
    endcase
  end

  assign mem_awaddr = addr_q;
  assign mem_araddr = addr_q;
  assign mem_awlen  = len_q;
  assign mem_arlen  = len_q;
  assign mem_awid   = grant;
  assign mem_arid   = grant;
  assign mem_wdata  = wdata_a[grant];
  assign mem_bready = 1'b1;
  assign mem_rready = 1'b1;
  assign req_rdata  = mem_rdata;

`ifdef MEM_ARB_PERF_CNT_EN
  // A requester waits while it has a request up and is neither being picked nor owning the port.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    logic owns;
    logic picked;
    assign owns   = (state != ARB_IDLE) && (grant == IDX_W'(g));
    assign picked = (state == ARB_IDLE) && pick_vld && (pick_idx == IDX_W'(g));
    always_ff @(posedge clk) begin
      if (rst) begin
        perf_grants[g] <= '0;
        perf_waits[g]  <= '0;
      end else begin
        if (picked && (perf_grants[g] != '1)) perf_grants[g] <= perf_grants[g] + 1'b1;
        if (cand[g] && !owns && !picked && (perf_waits[g] != '1)) perf_waits[g] <= perf_waits[g] + 1'b1;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: bench drives the memory side cycle by cycle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mem_port_arbiter;

  localparam int N  = 2;
  localparam int LW = 4;
  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_awvalid, req_awready, req_wvalid, req_wready, req_bvalid;
  logic [N-1:0]    req_arvalid, req_arready, req_rvalid;
  logic [N*AW-1:0] req_awaddr, req_araddr;
  logic [N*LW-1:0] req_awlen, req_arlen;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   req_rdata;
  logic            mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_wlast;
  logic            mem_bvalid, mem_bready, mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [AW-1:0]   mem_awaddr, mem_araddr;
  logic [LW-1:0]   mem_awlen, mem_arlen;
  logic [0:0]      mem_awid, mem_arid;
  logic [DW-1:0]   mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]     perf_grants [N];
  logic [31:0]     perf_waits  [N];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.NUM_REQ(N), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .req_awvalid(req_awvalid), .req_awaddr(req_awaddr), .req_awlen(req_awlen), .req_awready(req_awready),
    .req_wvalid(req_wvalid), .req_wdata(req_wdata), .req_wready(req_wready), .req_bvalid(req_bvalid),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arready(req_arready),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen),
    .mem_awid(mem_awid), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_wlast(mem_wlast), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
    .mem_arid(mem_arid), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_grants(perf_grants), .perf_waits(perf_waits)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    req_arvalid[id] = 1'b1;
    req_araddr[id*AW +: AW] = addr;
    req_arlen[id*LW +: LW] = len;
  endtask

  task automatic set_wr(input int id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    req_awvalid[id] = 1'b1;
    req_awaddr[id*AW +: AW] = addr;
    req_awlen[id*LW +: LW] = len;
  endtask

  // Waits (bounded) for the read address, accepts it, then streams rvalid for len+2 cycles
  // with arready held low so the next pending request cannot steal beats.
  task automatic serve_read(input int id, input logic [AW-1:0] addr, input int len,
                            input string tag, output int w);
    int p, o;
    logic [N-1:0] own;
    own = N'(1) << id;
    w = 0;
    mem_arready = 1'b0;
    #1;
    while (!mem_arvalid && w < 8) begin
      tick();
      #1;
      w++;
    end
    check({tag, "_arvalid"}, mem_arvalid, 1);
    check({tag, "_arid"}, mem_arid, id);
    check({tag, "_araddr"}, mem_araddr, addr);
    check({tag, "_arlen"}, mem_arlen, len);
    mem_arready = 1'b1;
    #1;
    check({tag, "_arready"}, req_arready, own);
    tick();
    mem_arready = 1'b0;
    req_arvalid[id] = 1'b0;
    mem_rvalid = 1'b1;
    p = 0;
    o = 0;
    for (int i = 0; i < len + 2; i++) begin
      mem_rdata = 32'hA000 + i;
      #1;
      if (req_rvalid == own) begin
        p++;
        if (req_rdata != mem_rdata) o++;
      end else if (req_rvalid != '0) begin
        o++;
      end
      tick();
    end
    mem_rvalid = 1'b0;
    check({tag, "_rbeats"}, p, len);
    check({tag, "_rstray"}, o, 0);
  endtask

  task automatic serve_write(input int id, input logic [AW-1:0] addr, input int len,
                             input bit toggle, input string tag);
    int w, beat, bad;
    logic [N-1:0] own;
    own = N'(1) << id;
    w = 0;
    mem_awready = 1'b0;
    #1;
    while (!mem_awvalid && w < 8) begin
      tick();
      #1;
      w++;
    end
    check({tag, "_awvalid"}, mem_awvalid, 1);
    check({tag, "_awid"}, mem_awid, id);
    check({tag, "_awaddr"}, mem_awaddr, addr);
    check({tag, "_awlen"}, mem_awlen, len);
    mem_awready = 1'b1;
    #1;
    check({tag, "_awready"}, req_awready, own);
    tick();
    mem_awready = 1'b0;
    req_awvalid[id] = 1'b0;
    req_wvalid[id] = 1'b1;
    beat = 0;
    bad = 0;
    for (int c = 0; c < 2 * len + 4 && beat < len; c++) begin
      mem_wready = toggle ? (c % 2 == 0) : 1'b1;
      req_wdata[id*DW +: DW] = 32'hB000 + beat;
      #1;
      if (mem_wvalid && mem_wready) begin
        if (mem_wdata != 32'hB000 + beat) bad++;
        if (mem_wlast != (beat == len - 1)) bad++;
        if (req_wready != own) bad++;
        beat++;
      end
      tick();
    end
    check({tag, "_wbeats"}, beat, len);
    check({tag, "_wbad"}, bad, 0);
    #1;
    check({tag, "_no_extra_w"}, mem_wvalid, 0);
    check({tag, "_b_wait"}, req_bvalid, 0);
    req_wvalid[id] = 1'b0;
    mem_wready = 1'b0;
    tick();
    mem_bvalid = 1'b1;
    #1;
    check({tag, "_bvalid"}, req_bvalid, own);
    tick();
    #1;
    check({tag, "_b_after"}, req_bvalid, 0);
    mem_bvalid = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    req_awvalid = '0; req_awaddr = '0; req_awlen = '0;
    req_wvalid = '0; req_wdata = '0;
    req_arvalid = '0; req_araddr = '0; req_arlen = '0;
    mem_awready = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_valids", {mem_awvalid, mem_wvalid, mem_arvalid, req_awready, req_wready,
                         req_bvalid, req_arready, req_rvalid}, 0);
    check("rst_readies", {mem_bready, mem_rready}, 2'b11);

    // single requester read, one-cycle arbitration latency
    set_rd(1, 32'h0100, 4);
    #1;
    check("t1_idle_no_arvalid", mem_arvalid, 0);
    serve_read(1, 32'h0100, 4, "t1", w);
    check("t1_latency", w, 1);

    // simultaneous reads: req0 first, then req1, and the pointer wraps back to 0
    set_rd(0, 32'h0200, 2);
    set_rd(1, 32'h0210, 3);
    serve_read(0, 32'h0200, 2, "t2a", w);
    serve_read(1, 32'h0210, 3, "t2b", w);
    set_rd(0, 32'h0220, 1);
    set_rd(1, 32'h0230, 1);
    serve_read(0, 32'h0220, 1, "t2c", w);
    serve_read(1, 32'h0230, 1, "t2d", w);

    // same requester write and read pending: write burst first
    set_wr(1, 32'h0500, 4);
    set_rd(1, 32'h0510, 4);
    serve_write(1, 32'h0500, 4, 1'b0, "t3w");
    serve_read(1, 32'h0510, 4, "t3r", w);

    // write with mem_wready toggling
    set_wr(0, 32'h0600, 4);
    serve_write(0, 32'h0600, 4, 1'b1, "t4");

    // zero length runs as a single beat
    set_rd(0, 32'h0700, 0);
    serve_read(0, 32'h0700, 1, "t_len0", w);

    // reset in the middle of a read burst
    set_rd(0, 32'h0300, 4);
    tick();
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    req_arvalid[0] = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    check("t5_beat1", req_rvalid, 2'b01);
    tick();
    #1;
    check("t5_beat2", req_rvalid, 2'b01);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t5_after_rst", {mem_awvalid, mem_wvalid, mem_arvalid, req_awready, req_wready,
                           req_bvalid, req_arready, req_rvalid}, 0);
    mem_rvalid = 1'b0;
    tick();
    set_rd(1, 32'h0400, 2);
    serve_read(1, 32'h0400, 2, "t5_fresh", w);
    check("t5_fresh_latency", w, 1);

`ifdef MEM_ARB_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_rd(1, 32'h0800, 4);
    tick();
    set_rd(0, 32'h0810, 1);
    serve_read(1, 32'h0800, 4, "t6_r1", w);
    serve_read(0, 32'h0810, 1, "t6_r0", w);
    #1;
    check("t6_waits0", perf_waits[0], 5);
    check("t6_waits1", perf_waits[1], 0);
    check("t6_grants0", perf_grants[0], 1);
    check("t6_grants1", perf_grants[1], 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
